encoder_sequencer: RTL and testbench
====================================

# encoder_sequencer

Round/stage sequencer for the matrix encoder. It runs NUM_STAGES function units (column parity, rotate, permute, …) in fixed order for ROUNDS rounds. It grants the single shared line memory to the active unit, and ping-pongs between two memory banks so each stage reads the previous stage's result. It sits above the per-function controller/datapath pairs and below the top-level encoder.

## Interface
Parameters:
- NUM_STAGES, 5, number of function units sequenced per round (index 0 runs first)
- ROUNDS, 24, rounds per encode; minimum 1
- LINE_W, 25, memory line width (5×5 matrix)
- ADDR_W, 7, per-unit line address width (unit counter value)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin encode; sampled only in IDLE
- stage_done  in  NUM_STAGES  per-unit done pulse
- stage_we  in  NUM_STAGES  per-unit write enable
- stage_addr  in  NUM_STAGES*ADDR_W  per-unit line address, unit k at [k*ADDR_W +: ADDR_W]
- stage_wdata  in  NUM_STAGES*LINE_W  per-unit write data, unit k at [k*LINE_W +: LINE_W]
- stage_start  out  NUM_STAGES  one-hot, one-cycle start pulse to the selected unit
- mem_rd_addr  out  ADDR_W+1  {bank, stage_addr[sel]}
- mem_wr_addr  out  ADDR_W+1  {~bank, stage_addr[sel]}
- mem_we  out  1  granted write enable
- mem_wdata  out  LINE_W  granted write data
- round_cnt  out  5  current round, 0..ROUNDS-1
- busy  out  1  high from LAUNCH through FINISH
- result_bank  out  1  bank holding the final result, valid when done pulses
- done  out  1  one-cycle completion pulse

## Operation
- Registers: state, sel (stage index), round_cnt, and bank. bank resets to 0.
- IDLE:
  - start=1 loads sel=0, round_cnt=0 and bank=0, then goes to LAUNCH.
  - start=0 stays in IDLE.
- LAUNCH: stage_start[sel]=1 for exactly one cycle, then WAIT.
- WAIT:
  - Grant is active: mem_we=stage_we[sel] and mem_wdata=stage_wdata[sel]. Addresses are muxed from sel.
  - stage_done[sel]=1 goes to ADVANCE. A write in the same cycle as done is still passed through.
- ADVANCE:
  - bank toggles.
  - If sel<NUM_STAGES-1: sel+1, go to LAUNCH.
  - Else if round_cnt<ROUNDS-1: sel=0, round_cnt+1, go to LAUNCH.
  - Else go to FINISH.
- FINISH: done=1 for one cycle; result_bank=bank; go to IDLE.
- Outside WAIT, mem_we=0. Addresses and data still follow sel (don't-care).
- stage_done on any bit ≠ sel is ignored in every state.
- start while busy is ignored; no queuing.
- Total bank toggles = NUM_STAGES*ROUNDS. result_bank = parity of that count (0 for the defaults: 5×24, even).

## Timing
- Reset values:
  - stage_start=0, mem_we=0, done=0, busy=0
  - round_cnt=0, result_bank=0
  - mem_rd_addr=0, mem_wr_addr={1,0}, mem_wdata=stage_wdata[0]
- Reset asserted mid-operation returns to IDLE immediately (asynchronous). The interrupted unit is not notified and must also be reset by rst.
- start at edge t gives stage_start[0] high during cycle t+1.
- Fixed overhead per stage is 2 cycles (LAUNCH + ADVANCE) plus the unit latency L.
- Encode latency from start to done = ROUNDS*NUM_STAGES*(L+2)+1 cycles after the start edge.
- stage_done[sel] arriving in LAUNCH is ignored. Units must not assert done earlier than 1 cycle after start.

## Structure
- Shared package encoder_pkg holds:
  - LINE_W and ADDR_W constants
  - state encoding: IDLE, LAUNCH, WAIT, ADVANCE, FINISH
- The grant mux (sel → addr/we/wdata) is a natural sub-module, mem_port_mux. It is purely combinational, parameterised by NUM_STAGES.
- The FSM and counters stay in encoder_sequencer.

## Test plan
- Reset check: rst=0 mid-WAIT with round_cnt=3 → next cycle busy=0, mem_we=0, round_cnt=0. Restart with start works normally.
- Single encode: NUM_STAGES=5, ROUNDS=2, stub units with L=64 → stage_start order 0,1,2,3,4,0,…,4, and done at start+2*5*66+1 = 661 cycles after the start edge.
- Bank ping-pong: stage 0 reads bank 0 and writes bank 1; stage 1 reads bank 1 and writes bank 0. With ROUNDS=1, result_bank=1 (5 toggles).
- Grant isolation: all inactive units drive stage_we=1 with wdata=0x1FFFFFF → mem_we and mem_wdata follow only the selected unit. mem_we=0 in LAUNCH and ADVANCE.
- Stray handshakes: stage_done[3] pulsed while sel=1, plus start pulsed while busy → no state change, and the encode completes with unchanged latency.
- Write coincident with done: unit asserts stage_we=1 at addr 63 in the same cycle as stage_done → the write appears on the memory port that cycle, and the next stage launches 2 cycles later.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and constants for the matrix encoder sequencer.
// Holds the memory line/address widths, the sequencer state encoding,
// the granted memory request payload and a select-width helper.
package encoder_pkg;

  localparam int unsigned LINE_W = 25;  // 5x5 matrix per memory line
  localparam int unsigned ADDR_W = 7;   // per-unit line address
  localparam int unsigned RND_W  = 5;   // round counter width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_ADVANCE,
    ST_FINISH
  } state_e;

  // Request presented to the shared line memory by the granted unit.
  typedef struct packed {
    logic              we;
    logic [ADDR_W:0]   rd_addr;
    logic [ADDR_W:0]   wr_addr;
    logic [LINE_W-1:0] wdata;
  } mem_req_t;

  // Width of a stage index; at least one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/encoder_sequencer_if.sv
// Handshake and memory-port bundle between the encoder sequencer and its
// surroundings (function units, line memory, top-level encoder).
//   master : drives start and per-unit done/we/addr/wdata
//   slave  : the sequencer; drives stage starts, memory port and status
interface encoder_sequencer_if
  import encoder_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5
);

  logic                         start;
  logic [NUM_STAGES-1:0]        stage_done;
  logic [NUM_STAGES-1:0]        stage_we;
  logic [NUM_STAGES*ADDR_W-1:0] stage_addr;
  logic [NUM_STAGES*LINE_W-1:0] stage_wdata;

  logic [NUM_STAGES-1:0]        stage_start;
  logic [ADDR_W:0]              mem_rd_addr;
  logic [ADDR_W:0]              mem_wr_addr;
  logic                         mem_we;
  logic [LINE_W-1:0]            mem_wdata;
  logic [RND_W-1:0]             round_cnt;
  logic                         busy;
  logic                         result_bank;
  logic                         done;

  modport master (
    output start, stage_done, stage_we, stage_addr, stage_wdata,
    input  stage_start, mem_rd_addr, mem_wr_addr, mem_we, mem_wdata,
           round_cnt, busy, result_bank, done
  );

  modport slave (
    input  start, stage_done, stage_we, stage_addr, stage_wdata,
    output stage_start, mem_rd_addr, mem_wr_addr, mem_we, mem_wdata,
           round_cnt, busy, result_bank, done
  );

endinterface

// File: rtl/mem_port_mux.sv
// Combinational grant mux: routes the selected unit's address, write enable
// and write data to the shared line memory. The read bank is the current
// bank and the write bank is its complement, so each stage consumes the
// previous stage's result. Write enable is suppressed unless granted.
//   sel_i         : active stage index
//   bank_i        : current read bank
//   grant_i       : memory grant (sequencer waiting on the unit)
//   stage_we_i    : per-unit write enables
//   stage_addr_i  : per-unit line addresses, unit k at [k*ADDR_W +: ADDR_W]
//   stage_wdata_i : per-unit write data, unit k at [k*LINE_W +: LINE_W]
//   mem_req_c_o   : granted memory request (combinational)
module mem_port_mux
  import encoder_pkg::*;
#(
  parameter  int unsigned NUM_STAGES = 5,
  localparam int unsigned SEL_W      = sel_width(NUM_STAGES)
) (
  input  logic [SEL_W-1:0]             sel_i,
  input  logic                         bank_i,
  input  logic                         grant_i,
  input  logic [NUM_STAGES-1:0]        stage_we_i,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr_i,
  input  logic [NUM_STAGES*LINE_W-1:0] stage_wdata_i,
  output mem_req_t                     mem_req_c_o
);

  logic [ADDR_W-1:0] addr_c;
  logic              we_c;
  logic [LINE_W-1:0] wdata_c;

  // Loop-based select keeps out-of-range indices (non power-of-two) safe.
  always_comb begin
    addr_c  = '0;
    we_c    = 1'b0;
    wdata_c = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (sel_i == SEL_W'(k)) begin
        addr_c  = stage_addr_i[k*ADDR_W +: ADDR_W];
        we_c    = stage_we_i[k];
        wdata_c = stage_wdata_i[k*LINE_W +: LINE_W];
      end
    end
    mem_req_c_o.we      = grant_i & we_c;
    mem_req_c_o.rd_addr = {bank_i, addr_c};
    mem_req_c_o.wr_addr = {~bank_i, addr_c};
    mem_req_c_o.wdata   = wdata_c;
  end

endmodule

// File: rtl/encoder_sequencer.sv
// Round/stage sequencer for the matrix encoder. Runs NUM_STAGES function
// units in fixed order for ROUNDS rounds, grants the shared line memory to
// the active unit and ping-pongs the memory bank after every stage.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of encoder_sequencer_if
//          in  start, stage_done, stage_we, stage_addr, stage_wdata
//          out stage_start (registered one-hot pulse), mem_rd_addr,
//              mem_wr_addr, mem_we, mem_wdata (granted, combinational),
//              round_cnt, busy, result_bank, done (registered)
module encoder_sequencer
  import encoder_pkg::*;
#(
  parameter  int unsigned NUM_STAGES = 5,
  parameter  int unsigned ROUNDS     = 24,
  localparam int unsigned SEL_W      = sel_width(NUM_STAGES)
) (
  input logic               clk,
  input logic               rst,
  encoder_sequencer_if.slave bus
);

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [RND_W-1:0]      round_q, round_d;
  logic                  bank_q, bank_d;
  logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  result_bank_q, result_bank_d;
  logic                  sel_done_c;
  logic                  grant_c;
  mem_req_t              mem_req_c;

  function automatic logic [NUM_STAGES-1:0] to_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_STAGES-1:0] oh;
    oh = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) oh[k] = (s == SEL_W'(k));
    return oh;
  endfunction

  // Only the selected unit's done bit is ever observed.
  assign sel_done_c = |(bus.stage_done & to_onehot(sel_q));
  assign grant_c    = (state_q == ST_WAIT);

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      round_q       <= '0;
      bank_q        <= 1'b0;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_bank_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      round_q       <= round_d;
      bank_q        <= bank_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_bank_q <= result_bank_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    round_d       = round_q;
    bank_d        = bank_q;
    result_bank_d = result_bank_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sel_d   = '0;
          round_d = '0;
          bank_d  = 1'b0;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (sel_done_c) state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        bank_d = ~bank_q;
        if (sel_q < SEL_W'(NUM_STAGES - 1)) begin
          sel_d   = sel_q + SEL_W'(1);
          state_d = ST_LAUNCH;
        end else if (round_q < RND_W'(ROUNDS - 1)) begin
          sel_d   = '0;
          round_d = round_q + RND_W'(1);
          state_d = ST_LAUNCH;
        end else begin
          result_bank_d = ~bank_q;
          state_d       = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs registered from the next state so they align with it.
    stage_start_d = (state_d == ST_LAUNCH) ? to_onehot(sel_d) : '0;
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_FINISH);
  end

  mem_port_mux #(
    .NUM_STAGES (NUM_STAGES)
  ) u_mem_port_mux (
    .sel_i         (sel_q),
    .bank_i        (bank_q),
    .grant_i       (grant_c),
    .stage_we_i    (bus.stage_we),
    .stage_addr_i  (bus.stage_addr),
    .stage_wdata_i (bus.stage_wdata),
    .mem_req_c_o   (mem_req_c)
  );

  assign bus.stage_start = stage_start_q;
  assign bus.mem_rd_addr = mem_req_c.rd_addr;
  assign bus.mem_wr_addr = mem_req_c.wr_addr;
  assign bus.mem_we      = mem_req_c.we;
  assign bus.mem_wdata   = mem_req_c.wdata;
  assign bus.round_cnt   = round_q;
  assign bus.busy        = busy_q;
  assign bus.result_bank = result_bank_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_encoder_sequencer.sv
// Bench for encoder_sequencer: random unit latencies and write traffic,
// checked cycle by cycle against a schedule computed from stage latencies.
module tb_encoder_sequencer;
  import encoder_pkg::*;

  localparam int unsigned S    = 5;
  localparam int unsigned R    = 5;
  localparam int unsigned MAXG = S * R;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  encoder_sequencer_if #(.NUM_STAGES(S)) bus ();

  encoder_sequencer #(
    .NUM_STAGES (S),
    .ROUNDS     (R)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [S-1:0]      we_v;
  logic [S-1:0]      done_v;
  logic [ADDR_W-1:0] addr_v [S];
  logic [LINE_W-1:0] wdata_v[S];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_bus();
    logic [S*ADDR_W-1:0] addr_p;
    logic [S*LINE_W-1:0] wdata_p;
    for (int k = 0; k < S; k++) begin
      addr_p[k*ADDR_W +: ADDR_W]  = addr_v[k];
      wdata_p[k*LINE_W +: LINE_W] = wdata_v[k];
    end
    bus.stage_we    = we_v;
    bus.stage_done  = done_v;
    bus.stage_addr  = addr_p;
    bus.stage_wdata = wdata_p;
  endtask

  task automatic drive_quiet();
    bus.start = 1'b0;
    done_v    = '0;
    we_v      = '1;
    for (int k = 0; k < S; k++) begin
      addr_v[k]  = '0;
      wdata_v[k] = '1;
    end
    drive_bus();
  endtask

  // One encode. fixed_lat>0 gives every unit that latency, else random 1..8.
  // noisy adds stray done/start pulses and a write coincident with done.
  // abort_g>=0 asserts reset two cycles into that stage's wait.
  task automatic run_encode(input int fixed_lat, input bit noisy, input int abort_g);
    int lat[MAXG];
    int lc[MAXG];
    int n_cyc;
    int gi;
    int act;
    int off;
    int phase;  // 0 launch, 1 wait, 2 advance, 3 finish
    logic [S-1:0] exp_ss;
    logic         bnk;

    for (int i = 0; i < MAXG; i++)
      lat[i] = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(8, 1));
    lc[0] = 1;
    for (int i = 1; i < MAXG; i++) lc[i] = lc[i-1] + lat[i-1] + 2;
    n_cyc = lc[MAXG-1] + lat[MAXG-1] + 2;

    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    gi = 0;

    for (int c = 1; c <= n_cyc; c++) begin
      while (gi < MAXG - 1 && c >= lc[gi] + lat[gi] + 2) gi++;
      act = gi % S;
      off = c - lc[gi];
      if (c == n_cyc)      phase = 3;
      else if (off == 0)   phase = 0;
      else if (off <= lat[gi]) phase = 1;
      else                 phase = 2;

      for (int k = 0; k < S; k++) begin
        we_v[k]    = 1'b1;
        wdata_v[k] = '1;
        addr_v[k]  = ADDR_W'($urandom);
        done_v[k]  = noisy && ($urandom_range(3, 0) == 0);
      end
      if (phase != 3) begin
        done_v[act] = 1'b0;
        if (phase == 0 && noisy) done_v[act] = $urandom_range(1, 0) == 1;
        if (phase == 1) begin
          we_v[act]    = $urandom_range(1, 0) == 1;
          wdata_v[act] = LINE_W'($urandom);
          if (off == lat[gi]) begin
            done_v[act] = 1'b1;
            if (noisy) begin
              we_v[act]   = 1'b1;
              addr_v[act] = ADDR_W'(63);
            end
          end
        end
      end
      bus.start = noisy && ($urandom_range(1, 0) == 1);
      drive_bus();
      #1;

      exp_ss = '0;
      if (phase == 0) exp_ss[act] = 1'b1;
      bnk = (gi % 2) != 0;
      chk("stage_start", 64'(bus.stage_start), 64'(exp_ss));
      chk("busy", 64'(bus.busy), 64'(1));
      chk("done", 64'(bus.done), 64'(phase == 3));
      chk("round_cnt", 64'(bus.round_cnt), (phase == 3) ? 64'(R - 1) : 64'(gi / S));
      chk("mem_we", 64'(bus.mem_we), (phase == 1) ? 64'(we_v[act]) : 64'(0));
      if (phase == 1) begin
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(wdata_v[act]));
        chk("mem_rd_addr", 64'(bus.mem_rd_addr), 64'({bnk, addr_v[act]}));
        chk("mem_wr_addr", 64'(bus.mem_wr_addr), 64'({~bnk, addr_v[act]}));
      end
      if (phase == 3) chk("result_bank", 64'(bus.result_bank), 64'((S * R) % 2));

      if (gi == abort_g && phase == 1 && off == 2) begin
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_mem_we", 64'(bus.mem_we), 64'(0));
        chk("abort_round", 64'(bus.round_cnt), 64'(0));
        chk("abort_stage_start", 64'(bus.stage_start), 64'(0));
        chk("abort_done", 64'(bus.done), 64'(0));
        drive_quiet();
        #3;
        rst = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end

    drive_quiet();
    #1;
    chk("idle_busy", 64'(bus.busy), 64'(0));
    chk("idle_done", 64'(bus.done), 64'(0));
  endtask

  initial begin
    rst = 1'b0;
    drive_quiet();
    wdata_v[0] = 25'h0ABCDE;
    drive_bus();
    #1;
    chk("rst_stage_start", 64'(bus.stage_start), 64'(0));
    chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_round", 64'(bus.round_cnt), 64'(0));
    chk("rst_result_bank", 64'(bus.result_bank), 64'(0));
    chk("rst_rd_addr", 64'(bus.mem_rd_addr), 64'(0));
    chk("rst_wr_addr", 64'(bus.mem_wr_addr), 64'(1 << ADDR_W));
    chk("rst_wdata", 64'(bus.mem_wdata), 64'(25'h0ABCDE));
    #11;
    rst = 1'b1;
    @(posedge clk); #1;

    run_encode(64, 1'b0, -1);
    run_encode(0, 1'b1, -1);
    run_encode(10, 1'b1, 3 * S + 1);
    run_encode(0, 1'b1, -1);
    run_encode(1, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
